// File: rtl/vx_mem_responder.sv
// vx_mem_responder: single-port line memory model with byte-enabled writes,
// fixed-latency in-order reads, and a bounded response queue. A read captures
// its line at acceptance, travels LATENCY stages (the last one being the FIFO
// write), then waits in the response FIFO until the consumer takes it.
module vx_mem_responder #(
    parameter int DATA_SIZE  = 64,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 4,
    parameter int RSP_QUEUE  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid_i,
    input  logic                     req_rw_i,
    input  logic [ADDR_WIDTH-1:0]    req_addr_i,
    input  logic [DATA_SIZE-1:0]     req_byteen_i,
    input  logic [DATA_SIZE*8-1:0]   req_data_i,
    input  logic [TAG_WIDTH-1:0]     req_tag_i,
    output logic                     req_ready_o,
    output logic                     rsp_valid_o,
    output logic [DATA_SIZE*8-1:0]   rsp_data_o,
    output logic [TAG_WIDTH-1:0]     rsp_tag_o,
    input  logic                     rsp_ready_i,
    output logic                     busy_o
);

    localparam int DW     = DATA_SIZE * 8;
    localparam int DEPTH  = 1 << DEPTH_LOG2;
    localparam int QW     = $clog2(RSP_QUEUE);
    localparam int CW     = $clog2(RSP_QUEUE + 1);
    localparam int PIPE_N = (LATENCY > 1) ? LATENCY - 1 : 1;

    logic [DW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  rsp_fire;

    logic                  push_vld;
    logic [DW-1:0]         push_data;
    logic [TAG_WIDTH-1:0]  push_tag;

    logic [DW-1:0]         fifo_data_q [RSP_QUEUE];
    logic [TAG_WIDTH-1:0]  fifo_tag_q  [RSP_QUEUE];
    logic [QW:0]           wr_ptr_q, wr_ptr_d;
    logic [QW:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;

    // Upper address bits alias onto the same lines and are deliberately dropped.
    assign idx = req_addr_i[DEPTH_LOG2-1:0];
    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^req_addr_i[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    // Ready depends only on registered state, and is forced low while in reset.
    assign req_ready_o = reset && (outstanding_q < CW'(RSP_QUEUE));
    assign busy_o      = (outstanding_q != '0);
    assign rd_fire     = req_valid_i && req_ready_o && !req_rw_i;
    assign wr_fire     = req_valid_i && req_ready_o &&  req_rw_i;
    assign rsp_valid_o = (wr_ptr_q != rd_ptr_q);
    assign rsp_data_o  = fifo_data_q[rd_ptr_q[QW-1:0]];
    assign rsp_tag_o   = fifo_tag_q[rd_ptr_q[QW-1:0]];
    assign rsp_fire    = rsp_valid_o && rsp_ready_i;

    // Byte-masked line write at the accept edge.
    // NOTE: storage carries no reset; clearing a RAM array is not possible in
    // real macros and unwritten lines are allowed to read as garbage.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_SIZE; b++) begin
            if (wr_fire && req_byteen_i[b]) begin
                mem_q[idx][b*8 +: 8] <= req_data_i[b*8 +: 8];
            end
        end
    end

    // Read pipeline: the line is captured at acceptance, so same-edge writes
    // from later requests can never leak into it.
    generate
        if (LATENCY > 1) begin : g_pipe
            logic                 pipe_vld_q  [PIPE_N];
            logic [DW-1:0]        pipe_data_q [PIPE_N];
            logic [TAG_WIDTH-1:0] pipe_tag_q  [PIPE_N];

            // Stage valids shift every cycle; the pipeline never stalls.
            // NOTE: sequential state uses non-blocking assignments so every
            // stage samples the previous stage's pre-edge value.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < PIPE_N; i++) pipe_vld_q[i] <= 1'b0;
                end else begin
                    pipe_vld_q[0] <= rd_fire;
                    for (int i = 1; i < PIPE_N; i++) pipe_vld_q[i] <= pipe_vld_q[i-1];
                end
            end

            // Payload shifts alongside the valids; it is qualified by them.
            always_ff @(posedge clk) begin
                pipe_data_q[0] <= mem_q[idx];
                pipe_tag_q[0]  <= req_tag_i;
                for (int i = 1; i < PIPE_N; i++) begin
                    pipe_data_q[i] <= pipe_data_q[i-1];
                    pipe_tag_q[i]  <= pipe_tag_q[i-1];
                end
            end

            assign push_vld  = pipe_vld_q[PIPE_N-1];
            assign push_data = pipe_data_q[PIPE_N-1];
            assign push_tag  = pipe_tag_q[PIPE_N-1];
        end else begin : g_nopipe
            assign push_vld  = rd_fire;
            assign push_data = mem_q[idx];
            assign push_tag  = req_tag_i;
        end
    endgenerate

    // Response FIFO storage write; the outstanding bound guarantees room.
    always_ff @(posedge clk) begin
        if (push_vld) begin
            fifo_data_q[wr_ptr_q[QW-1:0]] <= push_data;
            fifo_tag_q[wr_ptr_q[QW-1:0]]  <= push_tag;
        end
    end

    // Next-state for FIFO pointers and the outstanding-read counter.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        outstanding_d = outstanding_q;
        if (push_vld) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rsp_fire) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({rd_fire, rsp_fire})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Control state register; reset discards every in-flight and queued read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
        end
    end

endmodule
